// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer frame scheduler.
// TIMER_SNAP_EN adds the snapshot states to the state enum.
package timer_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_RUN,
    S_CLR_ST,
    S_TICK,
    S_WR_STOP
`ifdef TIMER_SNAP_EN
    , S_SNAP_WR,
    S_RD_L,
    S_RD_H
`endif
  } state_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD
  } bus_op_t;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;
  localparam logic [2:0] SNAPL   = 3'd4;
  localparam logic [2:0] SNAPH   = 3'd5;

  localparam int unsigned ITO   = 0;
  localparam int unsigned CONT  = 1;
  localparam int unsigned START = 2;
  localparam int unsigned STOP  = 3;

  localparam logic [3:0] CTRL_RUN_WORD  = 4'((1 << START) | (1 << CONT) | (1 << ITO));
  localparam logic [3:0] CTRL_STOP_WORD = 4'(1 << STOP);

endpackage

// File: rtl/timer_sched_bus.sv
// Registered Avalon-MM master driver: one write or read-address per cycle,
// idle bus (cs=0, write_n=1, addr/data=0) otherwise.
module timer_sched_bus
  import timer_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  bus_op_t     op,
  input  logic [2:0]  addr,
  input  logic [15:0] data,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
      unique case (op)
        OP_WR: begin
          m_address    <= addr;
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_writedata  <= data;
        end
        OP_RD:   m_address <= addr;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/timer_frame_scheduler.sv
// Interval-timer owner for the decoder path: programs/starts the timer, services
// its irq and emits frame_tick pulses. Optional TIMER_SNAP_EN adds snap_value.
module timer_frame_scheduler
  import timer_sched_pkg::*;
#(
  parameter int unsigned OVR_W     = 8,
  parameter logic [3:0]  CTRL_RUN  = CTRL_RUN_WORD,
  parameter logic [3:0]  CTRL_STOP = CTRL_STOP_WORD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      cfg_period,
  input  logic             cfg_valid,
  input  logic             stop_req,
  input  logic             frame_ack,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [15:0]      m_writedata,
  input  logic [15:0]      m_readdata,
  input  logic             timer_irq,
  output logic             frame_tick,
  output logic             busy,
  output logic             running,
  output logic             cfg_err,
  output logic [OVR_W-1:0] ovr_cnt
`ifdef TIMER_SNAP_EN
  , output logic [31:0]    snap_value
`endif
);

  state_t      state, next_state;
  logic [31:0] period_q;
  logic        pending, stop_pend;
  logic        cfg_ok, cfg_bad;
  bus_op_t     bus_op;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;

  always_comb begin
    next_state = state;
    cfg_ok     = 1'b0;
    cfg_bad    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_period != '0) begin
            cfg_ok     = 1'b1;
            next_state = S_WR_PL;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop_req || stop_pend) begin
          next_state = S_WR_STOP;
        end else if (cfg_valid) begin
          if (cfg_period != '0) begin
            cfg_ok     = 1'b1;
            next_state = S_WR_PL;
          end else begin
            cfg_bad = 1'b1;
          end
        end else if (timer_irq) begin
          next_state = S_CLR_ST;
        end
      end
      S_WR_PL:   next_state = S_WR_PH;
      S_WR_PH:   next_state = S_WR_CTRL;
      S_WR_CTRL: next_state = S_RUN;
`ifdef TIMER_SNAP_EN
      S_CLR_ST:  next_state = S_SNAP_WR;
      S_SNAP_WR: next_state = S_RD_L;
      S_RD_L:    next_state = S_RD_H;
      S_RD_H:    next_state = S_TICK;
`else
      S_CLR_ST:  next_state = S_TICK;
`endif
      S_TICK:    next_state = S_RUN;
      S_WR_STOP: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Bus command is decoded from next_state and registered, so each transfer is
  // presented in the same cycle the FSM sits in the matching state.
  always_comb begin
    bus_op   = OP_IDLE;
    bus_addr = '0;
    bus_data = '0;
    unique case (next_state)
      S_WR_PL:   begin bus_op = OP_WR; bus_addr = PERIODL; bus_data = cfg_period[15:0]; end
      S_WR_PH:   begin bus_op = OP_WR; bus_addr = PERIODH; bus_data = period_q[31:16]; end
      S_WR_CTRL: begin bus_op = OP_WR; bus_addr = CONTROL; bus_data = {12'h0, CTRL_RUN}; end
      S_CLR_ST:  begin bus_op = OP_WR; bus_addr = STATUS; end
      S_WR_STOP: begin bus_op = OP_WR; bus_addr = CONTROL; bus_data = {12'h0, CTRL_STOP}; end
`ifdef TIMER_SNAP_EN
      S_SNAP_WR: begin bus_op = OP_WR; bus_addr = SNAPL; end
      S_RD_L:    begin bus_op = OP_RD; bus_addr = SNAPL; end
      S_RD_H:    begin bus_op = OP_RD; bus_addr = SNAPH; end
`endif
      default: ;
    endcase
  end

  timer_sched_bus u_bus (
    .clk          (clk),
    .reset_n      (reset_n),
    .op           (bus_op),
    .addr         (bus_addr),
    .data         (bus_data),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      period_q   <= '0;
      pending    <= 1'b0;
      stop_pend  <= 1'b0;
      ovr_cnt    <= '0;
      frame_tick <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= next_state;
      frame_tick <= (next_state == S_TICK);
      cfg_err    <= cfg_bad;
      if (cfg_ok) begin
        period_q <= cfg_period;
        ovr_cnt  <= '0;
        pending  <= 1'b0;
      end else if (state == S_TICK) begin
        pending <= 1'b1;
        if (pending && (ovr_cnt != '1)) ovr_cnt <= ovr_cnt + 1'b1;
      end else if (frame_ack) begin
        pending <= 1'b0;
      end
      if (next_state == S_WR_STOP) begin
        stop_pend <= 1'b0;
      end else if (stop_req && busy && (state != S_WR_STOP)) begin
        stop_pend <= 1'b1;
      end
    end
  end

  assign busy = (state != S_IDLE) && (state != S_RUN);

`ifdef TIMER_SNAP_EN
  logic [15:0] snap_lo;

  assign running = (state == S_RUN) || (state == S_TICK) || (state == S_CLR_ST) ||
                   (state == S_SNAP_WR) || (state == S_RD_L) || (state == S_RD_H);

  // Timer read data lags the address by one cycle: low half arrives in RD_H,
  // high half in TICK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo    <= '0;
      snap_value <= '0;
    end else begin
      if (state == S_RD_H) snap_lo <= m_readdata;
      if (state == S_TICK) snap_value <= {m_readdata, snap_lo};
    end
  end
`else
  logic unused_readdata;

  assign running = (state == S_RUN) || (state == S_TICK) || (state == S_CLR_ST);
  assign unused_readdata = ^m_readdata;
`endif

endmodule
